// File: rtl/chip8_host_ctrl.sv
// chip8_host_ctrl: host bus decode, shared memory/reg-file port arbitration,
// PC and call stack ownership, and the run/pause/step/fault state machine.
// Optional breakpoint CSR (0x19) is built only when CHIP8_BREAKPOINT_EN is defined.
module chip8_host_ctrl #(
  parameter int unsigned ADDR_W      = 18,
  parameter int unsigned MEM_AW      = 12,
  parameter int unsigned STACK_DEPTH = 16,
  parameter logic [11:0] PC_RESET    = 12'h200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avs_chipselect,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic [31:0]       avs_writedata,
  output logic [31:0]       avs_readdata,
  output logic              avs_readdatavalid,
  input  logic [MEM_AW-1:0] cpu_mem_addr,
  input  logic              cpu_mem_we,
  input  logic [7:0]        cpu_mem_wdata,
  input  logic [3:0]        cpu_reg_addr,
  input  logic              cpu_reg_we,
  input  logic [7:0]        cpu_reg_wdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [3:0]        reg_addr,
  output logic              reg_we,
  output logic [7:0]        reg_wdata,
  input  logic [7:0]        reg_rdata,
  output logic              cpu_run,
  output logic              cpu_stall,
  input  logic              cpu_retire,
  input  logic              cpu_pc_we,
  input  logic [11:0]       cpu_pc_wdata,
  input  logic              cpu_push,
  input  logic              cpu_pop,
  output logic [11:0]       stack_top,
  output logic [11:0]       pc
);

  localparam int unsigned SP_IW = $clog2(STACK_DEPTH);
  localparam int unsigned SP_W  = SP_IW + 1;

  localparam logic [1:0] CMD_RUN   = 2'd0;
  localparam logic [1:0] CMD_PAUSE = 2'd1;
  localparam logic [1:0] CMD_STEP  = 2'd2;
  localparam logic [1:0] CMD_CLEAR = 2'd3;

  typedef enum logic [1:0] {
    ST_PAUSED  = 2'd0,
    ST_RUNNING = 2'd1,
    ST_STEP    = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SRC_CSR = 2'd0,
    SRC_MEM = 2'd1,
    SRC_REG = 2'd2
  } src_e;

  state_e            state_q;
  logic [1:0]        fault_q;
  logic [11:0]       pc_q, pc_d;
  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
  logic [11:0]       stack_q [STACK_DEPTH];
  logic              stall_q;
  logic              rd1_q;
  src_e              src1_q;
  logic [31:0]       csr1_q;
  logic [31:0]       csr_rdata;
  logic              bp_hit;
  logic              bp_fire;

  // Host access decode
  logic       access, host_rd, host_wr, win_mem, win_reg, wr_csr, wr_pc, wr_ctrl;
  logic [7:0] csr_a;
  logic [1:0] cmd;
  assign csr_a   = avs_address[7:0];
  assign cmd     = avs_writedata[1:0];
  assign access  = avs_chipselect & (avs_read | avs_write);
  assign host_rd = access & avs_read;
  assign host_wr = access & avs_write;
  assign win_mem = access & avs_address[16];
  assign win_reg = access & ~avs_address[16] & (csr_a[7:4] == 4'h0);
  assign wr_csr  = host_wr & ~avs_address[16];
  assign wr_pc   = wr_csr & (csr_a == 8'h14);
  assign wr_ctrl = wr_csr & (csr_a == 8'h16);

  logic unused_bits;
  assign unused_bits = ^{avs_writedata, avs_address, sp_m1};

  // Stack operation qualification and fault detection
  logic do_push, do_pop, ovf, unf, stack_fault;
  assign do_push     = cpu_push & ~cpu_pop;
  assign do_pop      = cpu_pop & ~cpu_push;
  assign ovf         = do_push & (sp_q == SP_W'(STACK_DEPTH));
  assign unf         = do_pop & (sp_q == '0);
  assign stack_fault = ovf | unf;
  assign sp_m1       = sp_q - SP_W'(1);
  assign stack_top   = (sp_q == '0) ? 12'h000 : stack_q[sp_m1[SP_IW-1:0]];

`ifdef CHIP8_BREAKPOINT_EN
  logic [12:0] bp_q;
  logic        bp_hit_q;
  logic        wr_bp;
  assign wr_bp   = wr_csr & (csr_a == 8'h19);
  assign bp_hit  = bp_hit_q;
  assign bp_fire = (state_q == ST_RUNNING) & bp_q[12] & cpu_retire & (pc_d == bp_q[11:0]);

  // Breakpoint CSR and sticky hit flag; a hit takes precedence over a CTRL clear
  always_ff @(posedge clk) begin
    if (reset) begin
      bp_q     <= 13'h0;
      bp_hit_q <= 1'b0;
    end else begin
      if (wr_bp) bp_q <= avs_writedata[12:0];
      if (bp_fire && !stack_fault) bp_hit_q <= 1'b1;
      else if (wr_ctrl) bp_hit_q <= 1'b0;
    end
  end
`else
  assign bp_hit  = 1'b0;
  assign bp_fire = 1'b0;
`endif

  // Shared port mux: host owns a port in the cycle it addresses that window
  always_comb begin
    mem_addr  = cpu_mem_addr;
    mem_we    = cpu_mem_we;
    mem_wdata = cpu_mem_wdata;
    reg_addr  = cpu_reg_addr;
    reg_we    = cpu_reg_we;
    reg_wdata = cpu_reg_wdata;
    if (win_mem) begin
      mem_addr  = avs_address[MEM_AW-1:0];
      mem_we    = host_wr;
      mem_wdata = avs_writedata[7:0];
    end
    if (win_reg) begin
      reg_addr  = csr_a[3:0];
      reg_we    = host_wr;
      reg_wdata = avs_writedata[7:0];
    end
    if (reset) begin
      mem_we = 1'b0;
      reg_we = 1'b0;
    end
  end

  assign cpu_stall = ~reset & (win_mem | win_reg | stall_q);
  assign cpu_run   = (state_q == ST_RUNNING) | (state_q == ST_STEP);
  assign pc        = pc_q;

  // Next PC: host write (outside RUNNING) beats a CPU load
  always_comb begin
    pc_d = pc_q;
    if (wr_pc && (state_q != ST_RUNNING)) pc_d = avs_writedata[11:0];
    else if (cpu_pc_we)                   pc_d = cpu_pc_wdata;
  end

  // Next stack pointer; faulting operations leave it unchanged
  always_comb begin
    sp_d = sp_q;
    if (do_push && !ovf) sp_d = sp_q + SP_W'(1);
    if (do_pop && !unf)  sp_d = sp_m1;
  end

  // CSR read mux, sampled in the first read stage
  always_comb begin
    csr_rdata = 32'h0;
    case (csr_a)
      8'h13: csr_rdata = 32'(sp_q);
      8'h14: csr_rdata = {20'h0, pc_q};
      8'h16: csr_rdata = {26'h0, fault_q, bp_hit, 1'b0, state_q};
      8'h18: csr_rdata = {20'h0, stack_top};
`ifdef CHIP8_BREAKPOINT_EN
      8'h19: csr_rdata = {19'h0, bp_q};
`endif
      default: csr_rdata = 32'h0;
    endcase
  end

  // Stack storage; contents intentionally not reset
  always_ff @(posedge clk) begin
    if (!reset && do_push && !ovf) stack_q[sp_q[SP_IW-1:0]] <= pc_q;
  end

  // PC, SP and stall-extension registers
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= PC_RESET;
      sp_q    <= '0;
      stall_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      stall_q <= win_mem | win_reg;
    end
  end

  // Emulator run state machine; a stack fault overrides any command
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_PAUSED;
      fault_q <= 2'd0;
    end else if (stack_fault) begin
      state_q <= ST_FAULT;
      fault_q <= ovf ? 2'd1 : 2'd2;
    end else begin
      case (state_q)
        ST_PAUSED: begin
          if (wr_ctrl && cmd == CMD_RUN)       state_q <= ST_RUNNING;
          else if (wr_ctrl && cmd == CMD_STEP) state_q <= ST_STEP;
        end
        ST_RUNNING: begin
          if ((wr_ctrl && cmd == CMD_PAUSE) || bp_fire) state_q <= ST_PAUSED;
        end
        ST_STEP: begin
          if (cpu_retire) state_q <= ST_PAUSED;
        end
        ST_FAULT: begin
          if (wr_ctrl && cmd == CMD_CLEAR) begin
            state_q <= ST_PAUSED;
            fault_q <= 2'd0;
          end
        end
        default: state_q <= ST_PAUSED;
      endcase
    end
  end

  // Two-stage read pipeline: RAM/reg-file data arrives one cycle after the address
  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_q             <= 1'b0;
      src1_q            <= SRC_CSR;
      csr1_q            <= 32'h0;
      avs_readdatavalid <= 1'b0;
      avs_readdata      <= 32'h0;
    end else begin
      rd1_q             <= host_rd;
      src1_q            <= win_mem ? SRC_MEM : (win_reg ? SRC_REG : SRC_CSR);
      csr1_q            <= csr_rdata;
      avs_readdatavalid <= rd1_q;
      if (rd1_q) begin
        case (src1_q)
          SRC_MEM: avs_readdata <= {24'h0, mem_rdata};
          SRC_REG: avs_readdata <= {24'h0, reg_rdata};
          default: avs_readdata <= csr1_q;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_chip8_host_ctrl.sv
// Directed bench for chip8_host_ctrl with behavioural RAM and reg-file models.
module tb_chip8_host_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        avs_chipselect, avs_read, avs_write;
  logic [17:0] avs_address;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [11:0] cpu_mem_addr;
  logic        cpu_mem_we;
  logic [7:0]  cpu_mem_wdata;
  logic [3:0]  cpu_reg_addr;
  logic        cpu_reg_we;
  logic [7:0]  cpu_reg_wdata;
  logic [11:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic [3:0]  reg_addr;
  logic        reg_we;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;
  logic        cpu_run, cpu_stall, cpu_retire, cpu_pc_we, cpu_push, cpu_pop;
  logic [11:0] cpu_pc_wdata;
  logic [11:0] stack_top, pc;

  int total = 0;
  int bad   = 0;

  logic [31:0] rd;
  logic        ok;

  always #5 clk = ~clk;

  chip8_host_ctrl dut (
    .clk(clk), .reset(reset),
    .avs_chipselect(avs_chipselect), .avs_read(avs_read), .avs_write(avs_write),
    .avs_address(avs_address), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .avs_readdatavalid(avs_readdatavalid),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_we(cpu_mem_we), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_reg_addr(cpu_reg_addr), .cpu_reg_we(cpu_reg_we), .cpu_reg_wdata(cpu_reg_wdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .reg_addr(reg_addr), .reg_we(reg_we), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata),
    .cpu_run(cpu_run), .cpu_stall(cpu_stall), .cpu_retire(cpu_retire),
    .cpu_pc_we(cpu_pc_we), .cpu_pc_wdata(cpu_pc_wdata),
    .cpu_push(cpu_push), .cpu_pop(cpu_pop),
    .stack_top(stack_top), .pc(pc)
  );

  // Synchronous RAM and register file, one-cycle read latency
  logic [7:0] ram [4096];
  logic [7:0] rf  [16];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
    if (reg_we) rf[reg_addr] <= reg_wdata;
    reg_rdata <= rf[reg_addr];
  end

  task automatic host_write(input logic [17:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_read = 1'b0;
    avs_address = a; avs_writedata = d;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
  endtask

  // Returns read data and whether valid pulsed exactly two cycles after the request
  task automatic host_read(input logic [17:0] a, output logic [31:0] d, output logic tok);
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_write = 1'b0; avs_address = a;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    tok = (avs_readdatavalid === 1'b0);
    @(negedge clk);
    tok = tok && (avs_readdatavalid === 1'b1);
    d = avs_readdata;
    @(negedge clk);
    tok = tok && (avs_readdatavalid === 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (cpu_stall !== 1'b0 || mem_we !== 1'b0 || reg_we !== 1'b0) begin
      bad++; $display("FAIL reset_port_ctl got stall=%b mem_we=%b reg_we=%b exp 0 0 0", cpu_stall, mem_we, reg_we);
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (pc !== 12'h200 || avs_readdatavalid !== 1'b0 || cpu_run !== 1'b0 || stack_top !== 12'h000) begin
      bad++; $display("FAIL reset_state got pc=%h rdv=%b run=%b top=%h exp 200 0 0 000", pc, avs_readdatavalid, cpu_run, stack_top);
    end
    host_read(18'h14, rd, ok);
    total++;
    if (rd !== 32'h200 || !ok) begin bad++; $display("FAIL reset_pc_read got=%h timing_ok=%b exp=00000200", rd, ok); end
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h0 || !ok) begin bad++; $display("FAIL reset_status_read got=%h timing_ok=%b exp=00000000", rd, ok); end
  endtask

  task automatic test_mem_window();
    @(negedge clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = 18'h10005; avs_writedata = 32'hAB;
    #1;
    total++;
    if (mem_we !== 1'b1 || mem_addr !== 12'h005 || mem_wdata !== 8'hAB || cpu_stall !== 1'b1) begin
      bad++; $display("FAIL mem_host_write got we=%b addr=%h data=%h stall=%b exp 1 005 ab 1", mem_we, mem_addr, mem_wdata, cpu_stall);
    end
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
    #1;
    total++;
    if (cpu_stall !== 1'b1 || mem_we !== 1'b0) begin
      bad++; $display("FAIL mem_stall_2nd got stall=%b we=%b exp 1 0", cpu_stall, mem_we);
    end
    @(negedge clk);
    total++;
    if (cpu_stall !== 1'b0) begin bad++; $display("FAIL mem_stall_end got=%b exp=0", cpu_stall); end
    host_read(18'h10005, rd, ok);
    total++;
    if (rd !== 32'hAB || !ok) begin bad++; $display("FAIL mem_readback got=%h timing_ok=%b exp=000000ab", rd, ok); end
  endtask

  task automatic test_reg_window();
    @(negedge clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = 18'h00003; avs_writedata = 32'h77;
    cpu_reg_we = 1'b1; cpu_reg_addr = 4'h9; cpu_reg_wdata = 8'h11;
    #1;
    total++;
    if (reg_we !== 1'b1 || reg_addr !== 4'h3 || reg_wdata !== 8'h77 || cpu_stall !== 1'b1) begin
      bad++; $display("FAIL reg_host_write got we=%b addr=%h data=%h stall=%b exp 1 3 77 1", reg_we, reg_addr, reg_wdata, cpu_stall);
    end
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write = 1'b0;
    #1;
    total++;
    if (reg_addr !== 4'h9 || reg_we !== 1'b1) begin
      bad++; $display("FAIL reg_cpu_pass got addr=%h we=%b exp 9 1", reg_addr, reg_we);
    end
    @(negedge clk);
    cpu_reg_we = 1'b0;
    host_read(18'h00003, rd, ok);
    total++;
    if (rd !== 32'h77 || !ok) begin bad++; $display("FAIL reg_readback got=%h timing_ok=%b exp=00000077", rd, ok); end
  endtask

  task automatic test_arbitration();
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 18'h10005;
    cpu_mem_we = 1'b1; cpu_mem_addr = 12'h123; cpu_mem_wdata = 8'h5A;
    #1;
    total++;
    if (mem_addr !== 12'h005 || mem_we !== 1'b0 || cpu_stall !== 1'b1) begin
      bad++; $display("FAIL arb_host_owns got addr=%h we=%b stall=%b exp 005 0 1", mem_addr, mem_we, cpu_stall);
    end
    @(negedge clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    #1;
    total++;
    if (mem_addr !== 12'h123 || mem_we !== 1'b1 || mem_wdata !== 8'h5A || cpu_stall !== 1'b1) begin
      bad++; $display("FAIL arb_cpu_lands got addr=%h we=%b data=%h stall=%b exp 123 1 5a 1", mem_addr, mem_we, mem_wdata, cpu_stall);
    end
    @(negedge clk);
    total++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'hAB || cpu_stall !== 1'b0) begin
      bad++; $display("FAIL arb_read_data got rdv=%b data=%h stall=%b exp 1 000000ab 0", avs_readdatavalid, avs_readdata, cpu_stall);
    end
    cpu_mem_we = 1'b0;
    host_read(18'h10123, rd, ok);
    total++;
    if (rd !== 32'h5A || !ok) begin bad++; $display("FAIL arb_cpu_write_kept got=%h timing_ok=%b exp=0000005a", rd, ok); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 18'h10005;
    @(negedge clk);
    avs_address = 18'h10123;
    total++;
    if (avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL b2b_early_valid got=%b exp=0", avs_readdatavalid); end
    @(negedge clk);
    avs_chipselect = 1'b0; avs_read = 1'b0;
    total++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'hAB) begin
      bad++; $display("FAIL b2b_first got rdv=%b data=%h exp 1 000000ab", avs_readdatavalid, avs_readdata);
    end
    @(negedge clk);
    total++;
    if (avs_readdatavalid !== 1'b1 || avs_readdata !== 32'h5A) begin
      bad++; $display("FAIL b2b_second got rdv=%b data=%h exp 1 0000005a", avs_readdatavalid, avs_readdata);
    end
    @(negedge clk);
    total++;
    if (avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop got=%b exp=0", avs_readdatavalid); end
  endtask

  task automatic test_fsm_pc();
    host_write(18'h14, 32'h240);
    total++;
    if (pc !== 12'h240) begin bad++; $display("FAIL pc_write_paused got=%h exp=240", pc); end
    host_write(18'h16, 32'h0);
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h1 || cpu_run !== 1'b1) begin bad++; $display("FAIL fsm_run got=%h run=%b exp 00000001 1", rd, cpu_run); end
    host_write(18'h14, 32'h300);
    total++;
    if (pc !== 12'h240) begin bad++; $display("FAIL pc_write_running got=%h exp=240", pc); end
    host_write(18'h16, 32'h2);
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL fsm_step_ignored got=%h exp=00000001", rd); end
    host_write(18'h16, 32'h1);
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h0 || cpu_run !== 1'b0) begin bad++; $display("FAIL fsm_pause got=%h run=%b exp 00000000 0", rd, cpu_run); end
    host_write(18'h16, 32'h2);
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h2 || cpu_run !== 1'b1) begin bad++; $display("FAIL fsm_step got=%h run=%b exp 00000002 1", rd, cpu_run); end
    @(negedge clk); cpu_retire = 1'b1;
    @(negedge clk); cpu_retire = 1'b0;
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h0 || cpu_run !== 1'b0) begin bad++; $display("FAIL fsm_step_done got=%h run=%b exp 00000000 0", rd, cpu_run); end
    @(negedge clk);
    avs_chipselect = 1'b1; avs_write = 1'b1; avs_address = 18'h14; avs_writedata = 32'h222;
    cpu_pc_we = 1'b1; cpu_pc_wdata = 12'h111;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_write = 1'b0; cpu_pc_we = 1'b0;
    total++;
    if (pc !== 12'h222) begin bad++; $display("FAIL pc_host_wins got=%h exp=222", pc); end
  endtask

  task automatic test_stack();
    host_write(18'h14, 32'h2A0);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        total++;
        if (stack_top !== 12'h30E) begin bad++; $display("FAIL stack_full_top got=%h exp=30e", stack_top); end
      end
      cpu_push = 1'b1; cpu_pc_we = 1'b1; cpu_pc_wdata = 12'(12'h300 + i);
    end
    @(negedge clk);
    cpu_push = 1'b0; cpu_pc_we = 1'b0;
    total++;
    if (pc !== 12'h310) begin bad++; $display("FAIL stack_pc got=%h exp=310", pc); end
    host_read(18'h13, rd, ok);
    total++;
    if (rd !== 32'd16) begin bad++; $display("FAIL ovf_sp got=%h exp=00000010", rd); end
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h13) begin bad++; $display("FAIL ovf_status got=%h exp=00000013", rd); end
    host_read(18'h18, rd, ok);
    total++;
    if (rd !== 32'h30E) begin bad++; $display("FAIL ovf_top_csr got=%h exp=0000030e", rd); end
    host_write(18'h16, 32'h3);
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL clear_fault got=%h exp=00000000", rd); end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 1) begin
        total++;
        if (stack_top !== 12'h30D) begin bad++; $display("FAIL pop_top got=%h exp=30d", stack_top); end
      end
      cpu_pop = 1'b1;
    end
    @(negedge clk);
    cpu_pop = 1'b0;
    total++;
    if (stack_top !== 12'h000) begin bad++; $display("FAIL empty_top got=%h exp=000", stack_top); end
    @(negedge clk); cpu_push = 1'b1; cpu_pop = 1'b1;
    @(negedge clk); cpu_push = 1'b0; cpu_pop = 1'b0;
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL push_pop_noop_status got=%h exp=00000000", rd); end
    host_read(18'h13, rd, ok);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL push_pop_noop_sp got=%h exp=00000000", rd); end
    @(negedge clk); cpu_pop = 1'b1;
    @(negedge clk); cpu_pop = 1'b0;
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h23) begin bad++; $display("FAIL unf_status got=%h exp=00000023", rd); end
    host_read(18'h13, rd, ok);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL unf_sp got=%h exp=00000000", rd); end
    host_write(18'h16, 32'h0);
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h23) begin bad++; $display("FAIL fault_ignores_run got=%h exp=00000023", rd); end
    host_write(18'h16, 32'h3);
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL clear_fault2 got=%h exp=00000000", rd); end
  endtask

`ifdef CHIP8_BREAKPOINT_EN
  task automatic test_breakpoint();
    host_write(18'h14, 32'h200);
    host_write(18'h19, 32'h1204);
    host_read(18'h19, rd, ok);
    total++;
    if (rd !== 32'h1204) begin bad++; $display("FAIL bp_csr got=%h exp=00001204", rd); end
    host_write(18'h16, 32'h0);
    @(negedge clk); cpu_retire = 1'b1; cpu_pc_we = 1'b1; cpu_pc_wdata = 12'h202;
    @(negedge clk); cpu_retire = 1'b0; cpu_pc_we = 1'b0;
    total++;
    if (pc !== 12'h202 || cpu_run !== 1'b1) begin bad++; $display("FAIL bp_not_yet got pc=%h run=%b exp 202 1", pc, cpu_run); end
    @(negedge clk); cpu_retire = 1'b1; cpu_pc_we = 1'b1; cpu_pc_wdata = 12'h204;
    @(negedge clk); cpu_retire = 1'b0; cpu_pc_we = 1'b0;
    total++;
    if (pc !== 12'h204 || cpu_run !== 1'b0) begin bad++; $display("FAIL bp_stop got pc=%h run=%b exp 204 0", pc, cpu_run); end
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h08) begin bad++; $display("FAIL bp_status got=%h exp=00000008", rd); end
    host_write(18'h16, 32'h0);
    host_read(18'h16, rd, ok);
    total++;
    if (rd !== 32'h01) begin bad++; $display("FAIL bp_hit_clear got=%h exp=00000001", rd); end
    host_write(18'h16, 32'h1);
  endtask
`else
  task automatic test_breakpoint_absent();
    host_write(18'h19, 32'h1204);
    host_read(18'h19, rd, ok);
    total++;
    if (rd !== 32'h0 || !ok) begin bad++; $display("FAIL bp_absent got=%h timing_ok=%b exp=00000000", rd, ok); end
  endtask
`endif

  task automatic test_reset_mid_read();
    @(negedge clk);
    avs_chipselect = 1'b1; avs_read = 1'b1; avs_address = 18'h14;
    @(negedge clk);
    avs_chipselect = 1'b0; avs_read = 1'b0; reset = 1'b1;
    @(negedge clk);
    total++;
    if (avs_readdatavalid !== 1'b0) begin bad++; $display("FAIL mid_read_valid1 got=%b exp=0", avs_readdatavalid); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (avs_readdatavalid !== 1'b0 || pc !== 12'h200) begin
      bad++; $display("FAIL mid_read_valid2 got rdv=%b pc=%h exp 0 200", avs_readdatavalid, pc);
    end
  endtask

  initial begin
    reset = 1'b1;
    avs_chipselect = 1'b0; avs_read = 1'b0; avs_write = 1'b0;
    avs_address = '0; avs_writedata = '0;
    cpu_mem_addr = '0; cpu_mem_we = 1'b0; cpu_mem_wdata = '0;
    cpu_reg_addr = '0; cpu_reg_we = 1'b0; cpu_reg_wdata = '0;
    cpu_retire = 1'b0; cpu_pc_we = 1'b0; cpu_pc_wdata = '0;
    cpu_push = 1'b0; cpu_pop = 1'b0;
    test_reset();
    test_mem_window();
    test_reg_window();
    test_arbitration();
    test_back_to_back();
    test_fsm_pc();
    test_stack();
`ifdef CHIP8_BREAKPOINT_EN
    test_breakpoint();
`else
    test_breakpoint_absent();
`endif
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/chip8_host_ctrl.md
Name: chip8_host_ctrl

Overview:
Parametrised host-side control block for the Chip-8 core. It decodes Avalon-MM slave accesses from the ARM into a memory window, a register-file window and control/status registers. It arbitrates the shared memory/register-file port between host and CPU, owns PC and the call stack, and runs the emulator run/pause/step/fault state machine. It sits between the bus slave and the CPU, memory and reg_file instances in the top level.

Parameters:
ADDR_W, 18, host word-address width
MEM_AW, 12, memory address width (4 KiB)
STACK_DEPTH, 16, call-stack entries (power of 2, 2..64)
PC_RESET, 12'h200, PC value after reset

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
avs_chipselect  in  1  host access valid
avs_read  in  1  host read
avs_write  in  1  host write
avs_address  in  ADDR_W  host word address
avs_writedata  in  32  host write data
avs_readdata  out  32  host read data
avs_readdatavalid  out  1  read data valid, fixed latency 2
cpu_mem_addr  in  MEM_AW  CPU memory address
cpu_mem_we  in  1  CPU memory write
cpu_mem_wdata  in  8  CPU memory write data
cpu_reg_addr  in  4  CPU register index
cpu_reg_we  in  1  CPU register write
cpu_reg_wdata  in  8  CPU register write data
mem_addr  out  MEM_AW  muxed memory address
mem_we  out  1  muxed memory write enable
mem_wdata  out  8  muxed memory write data
mem_rdata  in  8  memory read data (1-cycle sync RAM)
reg_addr  out  4  muxed reg-file address
reg_we  out  1  muxed reg-file write enable
reg_wdata  out  8  muxed reg-file write data
reg_rdata  in  8  reg-file read data (1-cycle)
cpu_run  out  1  CPU may issue/advance instructions
cpu_stall  out  1  CPU must hold this cycle (host owns port)
cpu_retire  in  1  one-cycle pulse, instruction completed
cpu_pc_we  in  1  CPU PC load
cpu_pc_wdata  in  12  CPU next PC
cpu_push  in  1  push pc onto stack
cpu_pop  in  1  pop stack
stack_top  out  12  top-of-stack value
pc  out  12  program counter

Behaviour:
- Access decode: access = chipselect & (read|write). address[16]=1 selects memory window, index address[MEM_AW-1:0]. Otherwise CSRs at address[7:0]:
  - 0x00-0x0F: registers V0-VF.
  - 0x14: PC, RW, 12 bits.
  - 0x13: SP, RO.
  - 0x16: CTRL/STATUS. Write cmd[1:0]: 0 RUN, 1 PAUSE, 2 STEP, 3 CLEAR_FAULT. Read {26'b0, fault[1:0], bp_hit, 1'b0, state[1:0]}.
  - 0x18: stack_top, RO.
  - Unmapped: reads return 0, writes are ignored.
- Read latency is exactly 2 cycles for every read. avs_readdatavalid is a 1-cycle pulse. Reads and writes are accepted back-to-back; no waitrequest.
- Arbitration: host has priority.
  - In a cycle where a host access targets the memory window, mem_* carries the host request and cpu_stall=1 for that cycle and the next.
  - The same rule applies to the reg-file window and reg_*.
  - Otherwise mem_* and reg_* pass the CPU signals through.
  - A CPU write is dropped in a host-owned cycle. The CPU must hold it under cpu_stall.
- State FSM, encoding 0 PAUSED, 1 RUNNING, 2 STEP, 3 FAULT. Reset state is PAUSED.
  - PAUSED: RUN goes to RUNNING; STEP goes to STEP.
  - RUNNING: PAUSE goes to PAUSED.
  - STEP: on cpu_retire go to PAUSED.
  - Any state on stack fault goes to FAULT.
  - FAULT: only CLEAR_FAULT, which goes to PAUSED and zeroes the fault field.
  - cpu_run = (state==RUNNING) | (state==STEP).
  - A command that is illegal in the current state is ignored.
- PC:
  - Host write loads PC only when state != RUNNING; otherwise it is ignored.
  - cpu_pc_we loads cpu_pc_wdata.
  - If both occur in the same cycle, the host wins.
- Stack:
  - The stack holds STACK_DEPTH×12 bits.
  - push writes pc to stack[sp] and then increments sp.
  - pop decrements sp.
  - stack_top = stack[sp-1]; it is 0 when sp==0.
  - Push when sp==STACK_DEPTH sets fault=1 (overflow), and sp is unchanged.
  - Pop when sp==0 sets fault=2 (underflow).
  - Push and pop in the same cycle is a no-op on sp.
- Reset values:
  - pc=PC_RESET, sp=0, state=PAUSED, fault=0, bp_hit=0.
  - avs_readdatavalid=0, avs_readdata=0.
  - mem_we=0, reg_we=0, cpu_stall=0.
  - Stack contents are not reset.
- Reset mid-read discards the pending readdatavalid.

Optional Feature:
Macro CHIP8_BREAKPOINT_EN.
- When defined: CSR 0x19 holds {valid, addr[11:0]}, RW, reset 0. In RUNNING, when valid and pc==addr after a retire, the FSM goes to PAUSED and bp_hit is set. A write to CTRL clears bp_hit.
- When undefined: 0x19 reads 0, writes are ignored, and bp_hit is constant 0.

Test Plan:
- Reset, then read 0x14 and 0x16 -> 0x200 and state 0; readdatavalid exactly 2 cycles after each read.
- Host write 0xAB to address 0x10005, then read it back -> mem_we pulse with addr 0x005; readdata=0xAB; cpu_stall high 2 cycles.
- CPU writing memory during a host read of the memory window -> mem_* shows the host address; cpu_stall=1; CPU write lands after the stall.
- Write RUN, then STEP -> state 1, STEP ignored; write PAUSE, then STEP, pulse cpu_retire -> state goes 2 then 0.
- 17 pushes with STACK_DEPTH=16 -> sp=16, state=FAULT, fault=1; CLEAR_FAULT -> PAUSED; pop at sp=0 -> fault=2.
- CHIP8_BREAKPOINT_EN: bp={1,0x204}, RUN, retires advance PC 0x200->0x202->0x204 -> PAUSED and bp_hit=1 on reaching 0x204.
